clock_timer: RTL and testbench

CLOCK_TIMER -- requirements
Module: clock_timer

---
 rtl/clock_timer.sv | 148 ++++++++++++++
 tb/tb_clock_timer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_timer.sv
// Tenths-of-a-second clock with up/down counting, pause/resume, clamped load,
// a countdown-complete pulse and a count-up rollover pulse.
module clock_timer #(
    parameter int unsigned DIV    = 5000000,
    parameter int unsigned HR_MAX = 23
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       down,
    input  logic       load,
    input  logic [3:0] ld_dsec,
    input  logic [5:0] ld_sec,
    input  logic [5:0] ld_min,
    input  logic [4:0] ld_hr,
    output logic [3:0] dsec,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [4:0] hr,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [4:0]     HR_TOP   = 5'(HR_MAX);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pre, pre_nx;
    logic          dir, dir_nx;
    logic [3:0]    dsec_nx, c_dsec;
    logic [5:0]    sec_nx, min_nx, c_sec, c_min;
    logic [4:0]    hr_nx, c_hr;
    logic          done_nx, wrap_nx;
    logic          tick, time_zero, clamp_zero;

    assign running = (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pre   <= '0;
            dir   <= 1'b0;
            dsec  <= '0;
            sec   <= '0;
            min   <= '0;
            hr    <= '0;
            done  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nx;
            pre   <= pre_nx;
            dir   <= dir_nx;
            dsec  <= dsec_nx;
            sec   <= sec_nx;
            min   <= min_nx;
            hr    <= hr_nx;
            done  <= done_nx;
            wrap  <= wrap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pre_nx   = pre;
        dir_nx   = dir;
        dsec_nx  = dsec;
        sec_nx   = sec;
        min_nx   = min;
        hr_nx    = hr;
        done_nx  = 1'b0;
        wrap_nx  = 1'b0;

        c_dsec     = (ld_dsec > 4'd9)  ? 4'd9  : ld_dsec;
        c_sec      = (ld_sec  > 6'd59) ? 6'd59 : ld_sec;
        c_min      = (ld_min  > 6'd59) ? 6'd59 : ld_min;
        c_hr       = (ld_hr   > HR_TOP) ? HR_TOP : ld_hr;
        clamp_zero = (c_dsec == '0) && (c_sec == '0) && (c_min == '0) && (c_hr == '0);
        time_zero  = (dsec == '0) && (sec == '0) && (min == '0) && (hr == '0);
        tick       = (state == RUN) && (pre == PRE_LAST);

        if (load) begin
            // load overrides any tick landing on the same edge
            dsec_nx = c_dsec;
            sec_nx  = c_sec;
            min_nx  = c_min;
            hr_nx   = c_hr;
            pre_nx  = '0;
            done_nx = (state == RUN) && dir && clamp_zero;
        end else begin
            if (state == RUN)
                pre_nx = tick ? '0 : pre + 1'b1;
            if (tick && !dir) begin
                if (dsec == 4'd9) begin
                    dsec_nx = '0;
                    if (sec == 6'd59) begin
                        sec_nx = '0;
                        if (min == 6'd59) begin
                            min_nx = '0;
                            if (hr >= HR_TOP) begin
                                hr_nx   = '0;
                                wrap_nx = 1'b1;
                            end else
                                hr_nx = hr + 1'b1;
                        end else
                            min_nx = min + 1'b1;
                    end else
                        sec_nx = sec + 1'b1;
                end else
                    dsec_nx = dsec + 1'b1;
            end else if (tick) begin
                if (dsec == '0) begin
                    dsec_nx = 4'd9;
                    if (sec == '0) begin
                        sec_nx = 6'd59;
                        if (min == '0) begin
                            min_nx = 6'd59;
                            hr_nx  = (hr == '0) ? HR_TOP : hr - 1'b1;
                        end else
                            min_nx = min - 1'b1;
                    end else
                        sec_nx = sec - 1'b1;
                end else
                    dsec_nx = dsec - 1'b1;
                done_nx = (dsec_nx == '0) && (sec_nx == '0) && (min_nx == '0) && (hr_nx == '0);
            end
        end

        case (state)
            IDLE: begin
                if (start && !stop && !(down && time_zero)) begin
                    state_nx = RUN;
                    dir_nx   = down;
                end
            end
            RUN: begin
                if (stop || done_nx)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_clock_timer.sv
// Randomised and directed checks of clock_timer against a total-deciseconds reference model.
module tb_clock_timer;

    localparam int DIV    = 4;
    localparam int HR_MAX = 1;
    localparam int P      = (HR_MAX + 1) * 36000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, down = 1'b0, load = 1'b0;
    logic [3:0] ld_dsec = '0;
    logic [5:0] ld_sec = '0, ld_min = '0;
    logic [4:0] ld_hr = '0;
    logic [3:0] dsec;
    logic [5:0] sec, min;
    logic [4:0] hr;
    logic       running, done, wrap;

    clock_timer #(.DIV(DIV), .HR_MAX(HR_MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .down(down), .load(load),
        .ld_dsec(ld_dsec), .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr),
        .dsec(dsec), .sec(sec), .min(min), .hr(hr),
        .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: time as total deciseconds since 0:00:00.0
    int m_t = 0, m_pre = 0;
    bit m_run = 0, m_dir = 0, m_done = 0, m_wrap = 0;

    logic [23:0] dut_vec;
    assign dut_vec = {hr, min, sec, dsec, running, done, wrap};

    function automatic logic [23:0] exp_vec();
        return {5'(m_t / 36000), 6'((m_t / 600) % 60), 6'((m_t / 10) % 60), 4'(m_t % 10),
                m_run, m_done, m_wrap};
    endfunction

    function automatic int clamp_total();
        int d, s, m, h;
        d = (ld_dsec > 9) ? 9 : int'(ld_dsec);
        s = (ld_sec > 59) ? 59 : int'(ld_sec);
        m = (ld_min > 59) ? 59 : int'(ld_min);
        h = (ld_hr > HR_MAX) ? HR_MAX : int'(ld_hr);
        return ((h * 60 + m) * 60 + s) * 10 + d;
    endfunction

    task automatic model_reset();
        m_t = 0; m_pre = 0; m_run = 0; m_dir = 0; m_done = 0; m_wrap = 0;
    endtask

    task automatic model_edge();
        int lt, nt, np;
        bit tk, acc, nd, nw, nr;
        if (!reset) begin
            model_reset();
            return;
        end
        lt  = clamp_total();
        tk  = m_run && (m_pre == DIV - 1);
        acc = start && !stop && !m_run && !(down && m_t == 0);
        nd = 0; nw = 0; nt = m_t; np = m_pre;
        if (load) begin
            nt = lt;
            np = 0;
            nd = m_run && m_dir && (lt == 0);
        end else begin
            if (m_run) np = tk ? 0 : m_pre + 1;
            if (tk && !m_dir) begin
                nw = (m_t == P - 1);
                nt = (m_t + 1) % P;
            end else if (tk) begin
                nt = (m_t + P - 1) % P;
                nd = (nt == 0);
            end
        end
        nr = m_run;
        if (acc) begin
            nr = 1;
            m_dir = down;
        end
        if (stop || nd) nr = 0;
        m_t = nt; m_pre = np; m_run = nr; m_done = nd; m_wrap = nw;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_ld(input int d, input int s, input int m, input int h);
        ld_dsec = 4'(d); ld_sec = 6'(s); ld_min = 6'(m); ld_hr = 5'(h);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", dut_vec, 24'h0);
        end
        for (int i = 0; i < 2; i++) step();
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_count_up();
        down = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL count_up cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_checks++;
        if ({running, sec, dsec} !== {1'b1, 6'd1, 4'd0}) begin
            n_fail++;
            $display("FAIL count_up_40: got run=%b sec=%0d dsec=%0d expected run=1 sec=1 dsec=0",
                     running, sec, dsec);
        end
    endtask

    task automatic test_wrap();
        stop = 1'b1;
        step();
        stop = 1'b0;
        set_ld(9, 59, 59, 1); load = 1'b1;
        step();
        load = 1'b0;
        down = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (i == 3) begin
                n_checks++;
                if ({hr, min, sec, dsec, running, done, wrap} !== {21'h0, 1'b1, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL wrap_pulse: got %h expected %h", dut_vec, {21'h0, 3'b101});
                end
            end
        end
        n_checks++;
        if (wrap !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_one_cycle: got %b expected 0", wrap);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_countdown();
        set_ld(2, 0, 0, 0); load = 1'b1;
        step();
        load = 1'b0;
        down = 1'b1; start = 1'b1;
        step();
        start = 1'b0; down = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL countdown cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (i == 3) begin
                n_checks++;
                if ({dsec, running} !== {4'd1, 1'b1}) begin
                    n_fail++;
                    $display("FAIL countdown_0.1: got dsec=%0d run=%b expected dsec=1 run=1", dsec, running);
                end
            end
            if (i == 7) begin
                n_checks++;
                if ({dsec, running, done} !== {4'd0, 1'b0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL countdown_done: got dsec=%0d run=%b done=%b expected 0 0 1",
                             dsec, running, done);
                end
            end
        end
        down = 1'b1; start = 1'b1;
        step();
        start = 1'b0; down = 1'b0;
        n_checks++;
        if ({running, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_zero_reject: got run=%b done=%b expected 0 0", running, done);
        end
    endtask

    task automatic test_clamp();
        set_ld(15, 63, 60, 31); load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if ({hr, min, sec, dsec} !== {5'd1, 6'd59, 6'd59, 4'd9}) begin
            n_fail++;
            $display("FAIL clamp: got %0d:%0d:%0d.%0d expected 1:59:59.9", hr, min, sec, dsec);
        end
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL clamp_model: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_start_stop();
        set_ld(0, 0, 0, 0); load = 1'b1;
        step();
        load = 1'b0;
        down = 1'b0; start = 1'b1; stop = 1'b1;
        step();
        stop = 1'b0;
        n_checks++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_same: got run=%b expected 0", running);
        end
        step();                 // start accepted
        start = 1'b0;
        step();
        stop = 1'b1;
        step();                 // second running edge, paused
        stop = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL resume cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            n_checks++;
            if (dsec !== 4'(i)) begin
                n_fail++;
                $display("FAIL resume_tick cyc%0d: got dsec=%0d expected %0d", i, dsec, i);
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_load_zero_down();
        set_ld(0, 5, 0, 0); load = 1'b1;
        step();
        load = 1'b0;
        down = 1'b1; start = 1'b1;
        step();
        start = 1'b0; down = 1'b0;
        for (int i = 0; i < 3; i++) step();
        set_ld(0, 0, 0, 0); load = 1'b1;
        step();
        load = 1'b0;
        n_checks++;
        if ({running, done, wrap} !== 3'b010) begin
            n_fail++;
            $display("FAIL load_zero_down: got run=%b done=%b wrap=%b expected 0 1 0", running, done, wrap);
        end
        step();
        n_checks++;
        if (dut_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL load_zero_after: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_async_reset();
        set_ld(3, 7, 2, 0); load = 1'b1;
        step();
        load = 1'b0;
        down = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (dut_vec !== 24'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", dut_vec, 24'h0);
        end
        for (int i = 0; i < 3; i++) step();
        #2 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL after_reset cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int mode;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            down  = 1'($urandom_range(0, 1));
            load  = ($urandom_range(0, 59) == 0);
            mode  = $urandom_range(0, 2);
            if (mode == 0)
                set_ld($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 31));
            else if (mode == 1)
                set_ld($urandom_range(0, 3), 0, 0, 0);
            else
                set_ld($urandom_range(7, 9), 59, 59, HR_MAX);
            step();
            n_checks++;
            if (dut_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        start = 1'b0; stop = 1'b0; load = 1'b0; down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_clamp();
        test_start_stop();
        test_load_zero_down();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
